// File: rtl/hilo_wbpipe_if.sv
// HI/LO writeback pipe bundle: EX request, pipeline control, architectural
// HI/LO feedback, forwarded values and WB commit strobes.
interface hilo_wbpipe_if #(
  parameter int unsigned DATA_W = 32
);
  logic              reg_stall;
  logic              flush;
  logic              ex_valid;
  logic              ex_hi_we;
  logic [DATA_W-1:0] ex_hi_data;
  logic              ex_lo_we;
  logic [DATA_W-1:0] ex_lo_data;
  logic [DATA_W-1:0] arch_hi;
  logic [DATA_W-1:0] arch_lo;
  logic [DATA_W-1:0] fwd_hi;
  logic [DATA_W-1:0] fwd_lo;
  logic              hi_write;
  logic [DATA_W-1:0] hi_write_data;
  logic              lo_write;
  logic [DATA_W-1:0] lo_write_data;
  logic              pending;

  modport master (
    output reg_stall, flush, ex_valid, ex_hi_we, ex_hi_data, ex_lo_we, ex_lo_data,
    output arch_hi, arch_lo,
    input  fwd_hi, fwd_lo, hi_write, hi_write_data, lo_write, lo_write_data, pending
  );

  modport slave (
    input  reg_stall, flush, ex_valid, ex_hi_we, ex_hi_data, ex_lo_we, ex_lo_data,
    input  arch_hi, arch_lo,
    output fwd_hi, fwd_lo, hi_write, hi_write_data, lo_write, lo_write_data, pending
  );
endinterface

// File: rtl/hilo_wbpipe.sv
// Carries HI/LO write requests from EX through MEM and WB slots, commits them
// at WB and forwards the youngest uncommitted value back to EX.
module hilo_wbpipe #(
  parameter int unsigned DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  hilo_wbpipe_if.slave bus
);

  typedef struct packed {
    logic              hi_we;
    logic [DATA_W-1:0] hi_data;
    logic              lo_we;
    logic [DATA_W-1:0] lo_data;
  } slot_t;

  slot_t m_slot;
  slot_t w_slot;
  slot_t ex_slot;
  logic  commit_en;

  // Data fields are zeroed whenever their enable is clear, so a bubble carries 0.
  always_comb begin
    ex_slot         = '0;
    ex_slot.hi_we   = bus.ex_valid & bus.ex_hi_we;
    ex_slot.lo_we   = bus.ex_valid & bus.ex_lo_we;
    ex_slot.hi_data = ex_slot.hi_we ? bus.ex_hi_data : '0;
    ex_slot.lo_data = ex_slot.lo_we ? bus.ex_lo_data : '0;
  end

  // Flush kills EX and MEM; the older W entry still commits via commit_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_slot <= '0;
      w_slot <= '0;
    end else if (bus.flush) begin
      m_slot <= '0;
      w_slot <= '0;
    end else if (!bus.reg_stall) begin
      w_slot <= m_slot;
      m_slot <= ex_slot;
    end
  end

  // W strobes only on the cycle it leaves the slot.
  assign commit_en         = ~bus.reg_stall | bus.flush;
  assign bus.hi_write      = w_slot.hi_we & commit_en;
  assign bus.lo_write      = w_slot.lo_we & commit_en;
  assign bus.hi_write_data = w_slot.hi_data;
  assign bus.lo_write_data = w_slot.lo_data;

  // Youngest wins: M, then W, then the architectural register.
  always_comb begin
    bus.fwd_hi = bus.arch_hi;
    bus.fwd_lo = bus.arch_lo;
    if (w_slot.hi_we) bus.fwd_hi = w_slot.hi_data;
    if (m_slot.hi_we) bus.fwd_hi = m_slot.hi_data;
    if (w_slot.lo_we) bus.fwd_lo = w_slot.lo_data;
    if (m_slot.lo_we) bus.fwd_lo = m_slot.lo_data;
  end

  assign bus.pending = m_slot.hi_we | m_slot.lo_we | w_slot.hi_we | w_slot.lo_we;

endmodule

// File: tb/tb_hilo_wbpipe.sv
// Directed bench for hilo_wbpipe; models the HI/LO register it writes into.
module tb_hilo_wbpipe;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  hilo_wbpipe_if #(.DATA_W(DATA_W)) bus ();

  hilo_wbpipe #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Architectural HI/LO register fed by the commit strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.arch_hi <= '0;
      bus.arch_lo <= '0;
    end else begin
      if (bus.hi_write) bus.arch_hi <= bus.hi_write_data;
      if (bus.lo_write) bus.arch_lo <= bus.lo_write_data;
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then let combinational outputs settle.
  task automatic drive(input logic stall, input logic fl, input logic valid,
                       input logic hwe, input logic [DATA_W-1:0] hdata,
                       input logic lwe, input logic [DATA_W-1:0] ldata);
    bus.reg_stall  = stall;
    bus.flush      = fl;
    bus.ex_valid   = valid;
    bus.ex_hi_we   = hwe;
    bus.ex_hi_data = hdata;
    bus.ex_lo_we   = lwe;
    bus.ex_lo_data = ldata;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_hi_write", 32'(bus.hi_write), 32'h0);
    step();
    rst = 1'b0;
    idle();
    check("rst_fwd_hi", bus.fwd_hi, 32'h0);
    check("rst_arch_hi", bus.arch_hi, 32'h0);
    check("rst_pending2", 32'(bus.pending), 32'h0);

    // Basic commit: MTHI at cycle 0.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
    check("basic_c0_hi_write", 32'(bus.hi_write), 32'h0);
    step(); idle();
    check("basic_c1_fwd_hi", bus.fwd_hi, 32'h1234_5678);
    check("basic_c1_hi_write", 32'(bus.hi_write), 32'h0);
    check("basic_c1_pending", 32'(bus.pending), 32'h1);
    step(); idle();
    check("basic_c2_fwd_hi", bus.fwd_hi, 32'h1234_5678);
    check("basic_c2_hi_write", 32'(bus.hi_write), 32'h1);
    check("basic_c2_hi_data", bus.hi_write_data, 32'h1234_5678);
    check("basic_c2_lo_write", 32'(bus.lo_write), 32'h0);
    step(); idle();
    check("basic_c3_arch_hi", bus.arch_hi, 32'h1234_5678);
    check("basic_c3_hi_write", 32'(bus.hi_write), 32'h0);
    check("basic_c3_lo_write", 32'(bus.lo_write), 32'h0);
    check("basic_c3_pending", 32'(bus.pending), 32'h0);

    // Priority and order: two MTLOs back to back.
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA_0001);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBBBB_0002);
    check("ord_c1_fwd_lo", bus.fwd_lo, 32'hAAAA_0001);
    step(); idle();
    check("ord_c2_fwd_lo", bus.fwd_lo, 32'hBBBB_0002);
    check("ord_c2_lo_write", 32'(bus.lo_write), 32'h1);
    check("ord_c2_lo_data", bus.lo_write_data, 32'hAAAA_0001);
    check("ord_c2_hi_write", 32'(bus.hi_write), 32'h0);
    step(); idle();
    check("ord_c3_lo_write", 32'(bus.lo_write), 32'h1);
    check("ord_c3_lo_data", bus.lo_write_data, 32'hBBBB_0002);
    check("ord_c3_fwd_lo", bus.fwd_lo, 32'hBBBB_0002);
    step(); idle();
    check("ord_c4_arch_lo", bus.arch_lo, 32'hBBBB_0002);
    check("ord_c4_lo_write", 32'(bus.lo_write), 32'h0);
    check("ord_c4_pending", 32'(bus.pending), 32'h0);

    // Stall: DEAD_BEEF sits in W for three stalled cycles.
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("stall_hi_write", 32'(bus.hi_write), 32'h0);
      check("stall_fwd_hi", bus.fwd_hi, 32'hDEAD_BEEF);
      check("stall_arch_hi", bus.arch_hi, 32'h1234_5678);
    end
    step(); idle();
    check("stall_rel_hi_write", 32'(bus.hi_write), 32'h1);
    check("stall_rel_hi_data", bus.hi_write_data, 32'hDEAD_BEEF);
    check("stall_rel_fwd_hi", bus.fwd_hi, 32'hDEAD_BEEF);
    step(); idle();
    check("stall_post_hi_write", 32'(bus.hi_write), 32'h0);
    check("stall_post_arch_hi", bus.arch_hi, 32'hDEAD_BEEF);
    check("stall_post_fwd_hi", bus.fwd_hi, 32'hDEAD_BEEF);

    // Flush with stall: W commits, M and EX are killed.
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 32'h0);
    check("flush_hi_write", 32'(bus.hi_write), 32'h1);
    check("flush_hi_data", bus.hi_write_data, 32'h1111_1111);
    check("flush_fwd_hi", bus.fwd_hi, 32'h2222_2222);
    for (int i = 0; i < 3; i++) begin
      step(); idle();
      check("flush_post_pending", 32'(bus.pending), 32'h0);
      check("flush_post_hi_write", 32'(bus.hi_write), 32'h0);
      check("flush_post_fwd_hi", bus.fwd_hi, 32'h1111_1111);
      check("flush_post_arch_hi", bus.arch_hi, 32'h1111_1111);
    end

    // Mixed: one entry writes both; invalid EX requests in between.
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 1'b1, 32'h6);
    for (int i = 0; i < 2; i++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0BAD, 1'b1, 32'hBAD1_1BAD);
    end
    check("mix_hi_write", 32'(bus.hi_write), 32'h1);
    check("mix_lo_write", 32'(bus.lo_write), 32'h1);
    check("mix_hi_data", bus.hi_write_data, 32'h5);
    check("mix_lo_data", bus.lo_write_data, 32'h6);
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0BAD, 1'b1, 32'hBAD1_1BAD);
      check("mix_post_hi_write", 32'(bus.hi_write), 32'h0);
      check("mix_post_lo_write", 32'(bus.lo_write), 32'h0);
      check("mix_post_pending", 32'(bus.pending), 32'h0);
      check("mix_post_hi_data", bus.hi_write_data, 32'h0);
      check("mix_post_arch_hi", bus.arch_hi, 32'h5);
      check("mix_post_arch_lo", bus.arch_lo, 32'h6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
